sequence_store_gen: RTL and testbench

- Produces and stores the colour sequence for the Genius/Simon game; sits directly upstream of the main game FSM.
- When the FSM is in GET_NEXT_SEQUENCE_ITEM it requests an append. The block draws a 2-bit item from a free-running LFSR and writes it to the next slot.
- During SHOW_SEQUENCE and COMPARISON the FSM reads stored items back by address.

---
 rtl/sequence_store_gen_pkg.sv | 22 ++
 rtl/sequence_store_gen_lfsr_gen.sv | 33 +++
 rtl/sequence_store_gen.sv | 123 ++++++++++++
 tb/tb_sequence_store_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_store_gen_pkg.sv
// Shared types and constants for the Genius/Simon sequence store.
// SEQ_NO_REPEAT_EN (optional) enables the back-to-back colour avoidance rule.
package sequence_store_gen_pkg;

  localparam int unsigned DATA_WIDTH = 2;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned SEQ_DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;

  typedef logic [DATA_WIDTH-1:0] item_t;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } gen_state_t;

  function automatic item_t next_colour(input item_t c);
    return c + 1'b1;
  endfunction

endpackage

// File: rtl/sequence_store_gen_lfsr_gen.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with lock-up reload.
module lfsr_gen
  import sequence_store_gen_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  output logic [LFSR_WIDTH-1:0] state_o
);

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] state_d;
  logic                  fb;

  always_comb begin
    fb = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
    if (state_q == '0) begin
      state_d = LFSR_SEED;
    end else begin
      state_d = {state_q[LFSR_WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/sequence_store_gen.sv
// Random colour sequence generator and store feeding the Simon game FSM.
// Optional macro SEQ_NO_REPEAT_EN: bump an item that would repeat the previous one.
module sequence_store_gen
  import sequence_store_gen_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  append_req_i,
  output logic                  append_ack_o,
  input  logic [ADDR_WIDTH-1:0] read_addr_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic [ADDR_WIDTH:0]   seq_len_o,
  output logic                  full_o,
  output logic                  overflow_o
);

  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(SEQ_DEPTH);

  gen_state_t            state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  ovf_q, ovf_d;
  logic                  ack_q, ack_d;
  item_t                 rd_q, rd_d;
  item_t                 mem_q [SEQ_DEPTH];

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  item_t                 wdata;
  item_t                 cand;
  logic                  full;
  logic [LFSR_WIDTH-1:0] lfsr_state;
  logic                  lfsr_unused;

  lfsr_gen u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (lfsr_state)
  );

  assign cand        = lfsr_state[DATA_WIDTH-1:0];
  assign lfsr_unused = ^lfsr_state[LFSR_WIDTH-1:DATA_WIDTH];
  assign full        = (len_q == LEN_MAX);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    ack_d   = 1'b0;
    we      = 1'b0;
    waddr   = len_q[ADDR_WIDTH-1:0];
    wdata   = cand;
`ifdef SEQ_NO_REPEAT_EN
    if ((len_q != '0) && (cand == mem_q[waddr - 1'b1])) begin
      wdata = next_colour(cand);
    end
`endif
    // clear has priority over everything, including a pending ack
    if (clear_i) begin
      state_d = S_IDLE;
      len_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (append_req_i) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            if (!full) begin
              we    = 1'b1;
              len_d = len_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        S_ACK:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Read uses the pre-edge length, so a slot written this edge reads back as 0.
  always_comb begin
    rd_d = '0;
    if ({1'b0, read_addr_i} < len_q) begin
      rd_d = mem_q[read_addr_i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SEQ_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign append_ack_o = ack_q;
  assign read_data_o  = rd_q;
  assign seq_len_o    = len_q;
  assign full_o       = full;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_sequence_store_gen.sv
// Directed self-checking bench for sequence_store_gen (table vectors + corner sequences).
module tb_sequence_store_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear_i = 1'b0;
  logic       append_req_i = 1'b0;
  logic       append_ack_o;
  logic [4:0] read_addr_i = '0;
  logic [1:0] read_data_o;
  logic [5:0] seq_len_o;
  logic       full_o;
  logic       overflow_o;

  int n_cmp = 0;
  int n_err = 0;

  sequence_store_gen dut (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_i),
    .append_req_i (append_req_i),
    .append_ack_o (append_ack_o),
    .read_addr_i  (read_addr_i),
    .read_data_o  (read_data_o),
    .seq_len_o    (seq_len_o),
    .full_o       (full_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev holds the state sampled at the most recent edge.
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] m_prev = 16'hACE1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = 16'hACE1;
    end else begin
      m_prev = m_lfsr;
      if (m_lfsr == 16'h0) m_lfsr = 16'hACE1;
      else m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  logic [1:0] exp_mem [32];
  int         exp_len = 0;
  logic       exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_reset();
    exp_len = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 2'd0;
  endtask

  task automatic sb_store(input logic [1:0] item);
    logic [1:0] st;
    if (exp_len < 32) begin
      st = item;
`ifdef SEQ_NO_REPEAT_EN
      if (exp_len > 0 && item == exp_mem[exp_len-1]) st = item + 2'd1;
`endif
      exp_mem[exp_len] = st;
      exp_len++;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  // Append; if target >= 0, wait for the LFSR to offer that colour first.
  task automatic do_append(input int target);
    bit found;
    found = (target < 0);
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (m_lfsr[1:0] == target[1:0]) found = 1;
    end
    if (!found) begin
      chk("append_target_timeout", 32'd0, 32'd1);
      return;
    end
    if (target < 0) @(negedge clk);
    append_req_i = 1'b1;
    @(posedge clk);
    #1;
    append_req_i = 1'b0;
    sb_store(m_prev[1:0]);
    chk("append_ack_hi", append_ack_o, 1'b1);
    chk("append_len", seq_len_o, exp_len);
    chk("append_full", full_o, exp_len == 32);
    chk("append_ovf", overflow_o, exp_ovf);
    @(posedge clk);
    #1;
    chk("append_ack_lo", append_ack_o, 1'b0);
  endtask

  task automatic rd_check(input int addr);
    @(negedge clk);
    read_addr_i = addr[4:0];
    @(posedge clk);
    #1;
    chk($sformatf("read[%0d]", addr), read_data_o,
        (addr < exp_len) ? exp_mem[addr] : 2'd0);
  endtask

  typedef struct {
    logic       clr;
    logic       req;
    logic [4:0] addr;
    logic [5:0] len;
    logic       ack;
    logic [1:0] rd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-computed from LFSR states ACE1, 59C3, B387, 670F, CE1E at edges 0..4.
    tbl[0] = '{1'b0, 1'b1, 5'd0, 6'd1, 1'b1, 2'd0};
    tbl[1] = '{1'b0, 1'b0, 5'd0, 6'd1, 1'b0, 2'd1};
    tbl[2] = '{1'b0, 1'b1, 5'd0, 6'd2, 1'b1, 2'd1};
    tbl[3] = '{1'b0, 1'b1, 5'd1, 6'd2, 1'b0, 2'd3};
    tbl[4] = '{1'b0, 1'b1, 5'd3, 6'd3, 1'b1, 2'd0};
    tbl[5] = '{1'b0, 1'b0, 5'd2, 6'd3, 1'b0, 2'd2};
    tbl[6] = '{1'b0, 1'b0, 5'd1, 6'd3, 1'b0, 2'd3};
    tbl[7] = '{1'b1, 1'b1, 5'd0, 6'd0, 1'b0, 2'd1};
    tbl[8] = '{1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0};

    #12;
    chk("reset_len", seq_len_o, 6'd0);
    chk("reset_ack", append_ack_o, 1'b0);
    chk("reset_rd", read_data_o, 2'd0);
    chk("reset_full", full_o, 1'b0);
    chk("reset_ovf", overflow_o, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      clear_i      = tbl[i].clr;
      append_req_i = tbl[i].req;
      read_addr_i  = tbl[i].addr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_len", i), seq_len_o, tbl[i].len);
      chk($sformatf("vec%0d_ack", i), append_ack_o, tbl[i].ack);
      chk($sformatf("vec%0d_rd", i), read_data_o, tbl[i].rd);
      chk($sformatf("vec%0d_full", i), full_o, 1'b0);
      chk($sformatf("vec%0d_ovf", i), overflow_o, 1'b0);
      @(negedge clk);
    end
    clear_i = 1'b0;
    append_req_i = 1'b0;

    // Async reset while an ack is being held.
    append_req_i = 1'b1;
    @(posedge clk);
    #2;
    append_req_i = 1'b0;
    chk("pre_rst_ack", append_ack_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_ack", append_ack_o, 1'b0);
    chk("midrst_len", seq_len_o, 6'd0);
    chk("midrst_rd", read_data_o, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    sb_reset();

    // First append after release samples 59C3 (one idle edge since release).
    do_append(-1);
    rd_check(0);
    chk("first_item_hand", read_data_o, 2'd3);

    for (int i = 1; i < 32; i++) do_append(-1);
    chk("fill_full", full_o, 1'b1);
    chk("fill_len", seq_len_o, 6'd32);
    chk("fill_ovf", overflow_o, 1'b0);
    for (int a = 0; a < 32; a++) rd_check(a);

    do_append(-1);
    chk("ovf_sticky", overflow_o, 1'b1);
    chk("ovf_len", seq_len_o, 6'd32);
    rd_check(31);
    do_append(-1);
    chk("ovf_still", overflow_o, 1'b1);

    // Plain clear, then read mask with length 2.
    @(negedge clk);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    sb_reset();
    chk("clr_len", seq_len_o, 6'd0);
    chk("clr_ovf", overflow_o, 1'b0);
    chk("clr_full", full_o, 1'b0);
    rd_check(0);
    do_append(-1);
    do_append(-1);
    rd_check(3);
    rd_check(1);

    // Clear arriving while an ack is pending drops it.
    @(negedge clk);
    append_req_i = 1'b1;
    @(posedge clk);
    #1;
    append_req_i = 1'b0;
    @(negedge clk);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    sb_reset();
    chk("clr_drop_ack", append_ack_o, 1'b0);
    chk("clr_drop_len", seq_len_o, 6'd0);

    // Clear collides with append at length 5.
    for (int i = 0; i < 5; i++) do_append(-1);
    chk("pre_coll_len", seq_len_o, 6'd5);
    @(negedge clk);
    clear_i = 1'b1;
    append_req_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    append_req_i = 1'b0;
    sb_reset();
    chk("coll_len", seq_len_o, 6'd0);
    chk("coll_ack", append_ack_o, 1'b0);
    chk("coll_ovf", overflow_o, 1'b0);
    @(posedge clk);
    #1;
    chk("coll_ack_next", append_ack_o, 1'b0);
    do_append(-1);
    chk("coll_after_len", seq_len_o, 6'd1);
    rd_check(0);
    rd_check(1);

    // Two consecutive items drawn as colour 2.
    @(negedge clk);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    sb_reset();
    do_append(2);
    do_append(2);
    rd_check(0);
    chk("norep_mem0", read_data_o, 2'd2);
    rd_check(1);
`ifdef SEQ_NO_REPEAT_EN
    chk("norep_mem1", read_data_o, 2'd3);
`else
    chk("norep_mem1", read_data_o, 2'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
